uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  Parametrised UART receiver, successor to the 8N1 fixed receiver. Configurable data width, stop bits,
//  optional parity; framing/parity error flags, false-start rejection, one-entry output holding register with
//  valid/ready handshake and sticky overrun flag. Sits between the board Rx pin and the operand loader of
//  the modular multiplier.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per bit (>=4); counter width = $clog2(CLKS_PER_BIT)
//  DATA_BITS     8    data bits per frame, 5..9, LSB first
//  STOP_BITS     1    1 or 2; every stop bit is sampled
//  PARITY_ODD    0    0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)
// PORTS
//  clock        in   1          system clock, all logic on posedge
//  reset        in   1          synchronous, active-high
//  Rx           in   1          asynchronous serial line, idle high
//  o_data       out  DATA_BITS  received word, stable while o_valid=1
//  o_valid      out  1          holding register full
//  i_ready      in   1          consumer accepts o_data when o_valid & i_ready
//  o_frame_err  out  1          qualifies o_data: a stop bit was sampled 0
//  o_parity_err out  1          qualifies o_data: parity mismatch (tied 0 without macro)
//  o_overrun    out  1          sticky: a completed frame was dropped; cleared only by reset
//  o_busy       out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, counters 0, o_data=0, o_valid=0, all error flags 0, o_busy=0,
//    synchroniser flops=1. Reset mid-frame aborts the frame and drops its partial data.
//  - Rx passes a 2-flop synchroniser (init 1); all sampling uses the synchronised value rx_s.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE:  cnt=0, bit idx=0; rx_s==0 -> START.
//    START: count to (CLKS_PER_BIT-1)/2; at that cycle rx_s==0 -> DATA with cnt=0, else IDLE (glitch
//           rejected, nothing delivered, no flag).
//    DATA:  every CLKS_PER_BIT cycles sample rx_s into shift[idx]; after bit DATA_BITS-1 -> PARITY (macro)
//           else STOP.
//    PARITY: one bit period, sample parity bit.
//    STOP:  STOP_BITS bit periods; each sample==0 sets a frame-error latch. After last stop sample -> IDLE
//           in the same cycle the frame completes (no wait for remaining half stop bit).
//  - Completion cycle (last stop sample): if o_valid==0 or i_ready==1 that cycle, load o_data, o_frame_err,
//    o_parity_err next edge and o_valid=1. If o_valid==1 and i_ready==0: frame dropped, old word kept,
//    o_overrun<=1.
//  - Handshake: o_valid & i_ready with no completion -> o_valid<=0 next edge; error flags cleared with it.
//    Simultaneous accept + completion: new word loaded, o_valid stays 1, no overrun.
//  - Latency: o_valid rises 1 cycle after the mid-point sample of the last stop bit (+2 sync cycles from pin).
//  - Frames with errors are still delivered; flags describe that word only.
//  - Counter compares use full-width widened constants; no wrap: cnt resets to 0 at each sample point.
//  - Line held low (break): START succeeds, frame completes with o_frame_err=1, o_data=0; FSM then waits in
//    IDLE and re-arms immediately (low line re-enters START; each break period yields error frames).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state present; parity bit sampled after data; expected = ^data
//    (even) or ~^data (odd per PARITY_ODD); mismatch sets o_parity_err with the word.
//  Undefined: no PARITY state, frame = start+DATA_BITS+stop; o_parity_err tied 0; PARITY_ODD ignored.
// TESTING  (CLKS_PER_BIT=16 in sim)
//  1. 8N1, send 0xA5, i_ready=1 -> o_valid pulses 1 cycle, o_data=0xA5, no flags, o_busy falls.
//  2. Rx low pulse 5 cycles then high -> no o_valid, FSM back in IDLE, o_busy 0 within 10 cycles.
//  3. i_ready=0, send 0x11 then 0x22 -> o_data stays 0x11, o_overrun=1; raise i_ready -> o_valid drops.
//  4. Send 0x3C with stop bit forced 0 -> o_data=0x3C, o_frame_err=1; STOP_BITS=2, second stop 0 -> same.
//  5. UART_RX_PARITY_EN, even, send 0x07 parity=0 -> o_parity_err=1; parity=1 -> o_parity_err=0.
//  6. DATA_BITS=5, send 0x15; assert reset mid-DATA -> all outputs 0, next 0x0A received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with framing/parity flags and a one-word holding register.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_rx_frame: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t               state;
   logic                 rx_m;
   logic                 rx_s;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 ferr_l;
   logic                 bit_end;
   logic                 done;
   logic                 ferr_next;
   logic                 perr_next;

`ifdef UART_RX_PARITY_EN
   localparam logic ODD = (PARITY_ODD != 0);
   logic par_bit;
   assign perr_next = par_bit ^ (^shift) ^ ODD;
`else
   assign perr_next = 1'b0;
`endif

   assign bit_end   = (cnt == CNT_BIT);
   assign done      = (state == S_STOP) && bit_end && (stop_idx == STOP_LAST);
   assign ferr_next = ferr_l | ~rx_s;
   assign o_busy    = (state != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         stop_idx <= 1'b0;
         shift    <= '0;
         ferr_l   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else begin
         rx_m <= Rx;
         rx_s <= rx_m;
         case (state)
            S_IDLE: begin
               cnt      <= '0;
               idx      <= '0;
               stop_idx <= 1'b0;
               if (!rx_s) begin
                  state  <= S_START;
                  ferr_l <= 1'b0;
               end
            end
            // mid-bit recheck rejects short glitches on the line
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt   <= '0;
                  state <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  cnt        <= '0;
                  shift[idx] <= rx_s;
                  if (idx == IDX_LAST) begin
                     idx <= '0;
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  cnt     <= '0;
                  par_bit <= rx_s;
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (bit_end) begin
                  cnt    <= '0;
                  ferr_l <= ferr_next;
                  if (stop_idx == STOP_LAST) begin
                     state <= S_IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // holding register: accept and completion in one cycle keeps o_valid high
   always_ff @(posedge clock) begin
      if (reset) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
         o_overrun    <= 1'b0;
      end else if (done) begin
         if (!o_valid || i_ready) begin
            o_data       <= shift;
            o_valid      <= 1'b1;
            o_frame_err  <= ferr_next;
            o_parity_err <= perr_next;
         end else begin
            o_overrun <= 1'b1;
         end
      end else if (o_valid && i_ready) begin
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised bench for uart_rx_frame against a frame-level expected-word queue.
// Accepted words are captured by a monitor and compared in order.
module tb_uart_rx_frame;

   localparam int CPB  = 16;
   localparam int DW   = 8;
   localparam int SB   = 1;
   localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 1 + DW + 1 + SB;
`else
   localparam int NBITS = 1 + DW + SB;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          Rx = 1'b1;
   logic          i_ready = 1'b0;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          o_frame_err;
   logic          o_parity_err;
   logic          o_overrun;
   logic          o_busy;

   int checks = 0;
   int failures = 0;

   logic [DW+1:0] exp_q[$];
   logic [DW+1:0] rcv_q[$];

   uart_rx_frame #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DW),
      .STOP_BITS   (SB),
      .PARITY_ODD  (PODD)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .Rx          (Rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_parity_err(o_parity_err),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock)
      if (!reset && o_valid && i_ready)
         rcv_q.push_back({o_data, o_frame_err, o_parity_err});

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drive_bit(input logic v, input int n);
      Rx = v;
      repeat (n) @(negedge clock);
   endtask

   // bad: last stop bit low for most of its period; keep: word expected out
   task automatic send_frame(input logic [DW-1:0] d, input logic bad,
                             input logic pflip, input logic keep);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < DW; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ (PODD != 0) ^ pflip, CPB);
`endif
      for (int s = 0; s < SB; s++) begin
         if (bad && s == SB - 1) begin
            drive_bit(1'b0, 12);
            drive_bit(1'b1, CPB - 12);
         end else begin
            drive_bit(1'b1, CPB);
         end
      end
      if (keep) exp_q.push_back({d, bad, pflip});
   endtask

   task automatic expect_word(input string tag);
      logic [DW+1:0] g;
      logic [DW+1:0] e;
      int n = 0;
      while (rcv_q.size() == 0 && n < 64) begin
         @(negedge clock);
         n++;
      end
      if (rcv_q.size() == 0 || exp_q.size() == 0) begin
         check({tag, "_timeout"}, rcv_q.size(), exp_q.size() + 1);
      end else begin
         g = rcv_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_data"}, g[DW+1:2], e[DW+1:2]);
         check({tag, "_ferr"}, g[1], e[1]);
         check({tag, "_perr"}, g[0], e[0]);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_valid"}, o_valid, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      logic bad;
      logic pf;

      idle(4);
      check("rst_data", o_data, 0);
      check("rst_flags", {o_frame_err, o_parity_err, o_overrun}, 0);
      check_quiet("rst");
      reset = 1'b0;
      idle(3);
      check_quiet("post_rst");

      i_ready = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      expect_word("a5");
      idle(20);
      check_quiet("a5_idle");

      for (int k = 0; k < 16; k++) begin
         d = DW'($urandom);
         bad = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
         pf = $urandom_range(0, 1) == 1;
`else
         pf = 1'b0;
`endif
         send_frame(d, bad, pf, 1'b1);
         expect_word("rnd");
         idle(20);
         check("rnd_busy", o_busy, 0);
      end

      // break: line low across a whole frame and most of the stop bit
      drive_bit(1'b0, CPB * NBITS - 4);
`ifdef UART_RX_PARITY_EN
      exp_q.push_back({DW'(0), 1'b1, 1'(PODD != 0)});
`else
      exp_q.push_back({DW'(0), 1'b1, 1'b0});
`endif
      drive_bit(1'b1, 4);
      expect_word("break");
      idle(24);
      check_quiet("break_idle");
      check("break_extra", rcv_q.size(), 0);

      drive_bit(1'b0, 5);
      drive_bit(1'b1, 10);
      check("glitch_busy", o_busy, 0);
      idle(10);
      check_quiet("glitch");
      check("glitch_words", rcv_q.size(), 0);

      i_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      idle(4);
      check("ovr_v1", o_valid, 1);
      check("ovr_d1", o_data, 8'h11);
      check("ovr_o1", o_overrun, 0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0);
      idle(4);
      check("ovr_d2", o_data, 8'h11);
      check("ovr_v2", o_valid, 1);
      check("ovr_o2", o_overrun, 1);
      i_ready = 1'b1;
      expect_word("ovr");
      @(negedge clock);
      check("ovr_drop", o_valid, 0);
      check("ovr_sticky", o_overrun, 1);

      d = DW'($urandom);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
      reset = 1'b1;
      Rx = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_rst_data", o_data, 0);
      check("mid_rst_flags", {o_frame_err, o_parity_err, o_overrun}, 0);
      check_quiet("mid_rst");
      idle(4);
      d = DW'($urandom);
      send_frame(d, 1'b0, 1'b0, 1'b1);
      expect_word("after_rst");
      idle(20);
      check("left_exp", exp_q.size(), 0);
      check("left_rcv", rcv_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
